// File: rtl/elevator_pkg.sv
// Shared constants and scheduler state encoding for the elevator floor-request path.
package elevator_pkg;

  localparam int NUM_FLOORS = 16;
  localparam int FLOOR_W    = 4;

  // Floor 0 doubles as the "no request" code on the controller interface.
  localparam logic [FLOOR_W-1:0] NO_FLOOR = '0;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SELECT      = 2'd1,
    OFFER       = 2'd2,
    WAIT_ARRIVE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/button_debounce.sv
// One call button: 2-flop synchronizer, stable-sample debouncer, registered rising-edge pulse.
// Latency: press to rise_o is 2 + DEBOUNCE_CYCLES cycles; no backpressure.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       level_q;
  logic       rise_q;
  logic [3:0] cnt_q;
  logic       accept;

  // Accept the new level once DEBOUNCE_CYCLES consecutive samples disagree with it.
  assign accept = (sync2_q != level_q) && (cnt_q == 4'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      rise_q  <= accept && sync2_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/floor_request_scheduler.sv
// Latches debounced floor calls and offers targets in sweep (elevator) order.
// Latency: pending set to req_valid is 2 cycles from IDLE; offer held until req_ready.
module floor_request_scheduler #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_FLOORS      = elevator_pkg::NUM_FLOORS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_FLOORS-1:0]            call_btn,
  input  logic [elevator_pkg::FLOOR_W-1:0] current_floor,
  input  logic                             arrived,
  input  logic                             req_ready,
  output logic [elevator_pkg::FLOOR_W-1:0] req_floor,
  output logic                             req_valid,
  output logic [NUM_FLOORS-1:0]            pending,
  output logic                             dir_up
);
  import elevator_pkg::*;

  sched_state_e          state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    target_q, target_d;
  logic                  dir_up_q, dir_up_d;

  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] set_vec;
  logic [NUM_FLOORS-1:0] clr_vec;

  logic [FLOOR_W-1:0] lo_ge, lo_gt, hi_lt, hi_le;
  logic               lo_ge_vld, lo_gt_vld, hi_lt_vld, hi_le_vld;

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .btn_i (call_btn[f]),
      .rise_o(rise[f])
    );
  end

  // Floor 0 is the "no request" code, so its button never latches.
  assign set_vec = rise & ~NUM_FLOORS'(1);

  always_comb begin
    clr_vec = '0;
    if (state_q == WAIT_ARRIVE && arrived) begin
      clr_vec[current_floor] = 1'b1;
    end
    pending_d = (pending_q | set_vec) & ~clr_vec;
  end

  always_comb begin
    lo_ge     = NO_FLOOR;
    lo_gt     = NO_FLOOR;
    hi_lt     = NO_FLOOR;
    hi_le     = NO_FLOOR;
    lo_ge_vld = 1'b0;
    lo_gt_vld = 1'b0;
    hi_lt_vld = 1'b0;
    hi_le_vld = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i]) begin
        if (i >= int'(current_floor) && !lo_ge_vld) begin
          lo_ge     = FLOOR_W'(i);
          lo_ge_vld = 1'b1;
        end
        if (i > int'(current_floor) && !lo_gt_vld) begin
          lo_gt     = FLOOR_W'(i);
          lo_gt_vld = 1'b1;
        end
        if (i < int'(current_floor)) begin
          hi_lt     = FLOOR_W'(i);
          hi_lt_vld = 1'b1;
        end
        if (i <= int'(current_floor)) begin
          hi_le     = FLOOR_W'(i);
          hi_le_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dir_up_d = dir_up_q;
    unique case (state_q)
      IDLE: begin
        if (pending_q != '0) state_d = SELECT;
      end
      SELECT: begin
        if (pending_q == '0) begin
          state_d = IDLE;
        end else begin
          state_d = OFFER;
          if (dir_up_q) begin
            if (lo_ge_vld) begin
              target_d = lo_ge;
            end else if (hi_lt_vld) begin
              target_d = hi_lt;
              dir_up_d = 1'b0;
            end
          end else begin
            if (hi_le_vld) begin
              target_d = hi_le;
            end else if (lo_gt_vld) begin
              target_d = lo_gt;
              dir_up_d = 1'b1;
            end
          end
        end
      end
      OFFER: begin
        if (req_ready) state_d = WAIT_ARRIVE;
      end
      WAIT_ARRIVE: begin
        if (arrived && current_floor == target_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      target_q  <= NO_FLOOR;
      dir_up_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      dir_up_q  <= dir_up_d;
    end
  end

  assign req_valid = (state_q == OFFER);
  assign req_floor = req_valid ? target_q : NO_FLOOR;
  assign pending   = pending_q;
  assign dir_up    = dir_up_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler with hand-derived cycle timing.
module tb_floor_request_scheduler;

  logic        clk;
  logic        reset;
  logic [15:0] call_btn;
  logic [3:0]  current_floor;
  logic        arrived;
  logic        req_ready;
  logic [3:0]  req_floor;
  logic        req_valid;
  logic [15:0] pending;
  logic        dir_up;

  int total = 0;
  int bad   = 0;
  logic saw_valid;

  floor_request_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .NUM_FLOORS     (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .call_btn     (call_btn),
    .current_floor(current_floor),
    .arrived      (arrived),
    .req_ready    (req_ready),
    .req_floor    (req_floor),
    .req_valid    (req_valid),
    .pending      (pending),
    .dir_up       (dir_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset         = 1'b1;
    call_btn      = '0;
    current_floor = 4'd0;
    arrived       = 1'b0;
    req_ready     = 1'b0;
    step(2);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_valid", 32'(req_valid), 32'h0);
    chk("rst_floor", 32'(req_floor), 32'h0);
    chk("rst_dir", 32'(dir_up), 32'h1);
    reset = 1'b0;

    // Floor 5 press from floor 0; pending lands 7 edges after the press.
    req_ready   = 1'b1;
    call_btn[5] = 1'b1;
    step(6);
    chk("a_pend_early", 32'(pending), 32'h0);
    step(1);
    chk("a_pend_set", 32'(pending), 32'h0020);
    step(1);
    chk("a_select_novalid", 32'(req_valid), 32'h0);
    step(1);
    chk("a_offer", 32'({req_valid, req_floor}), 32'h15);
    chk("a_dir", 32'(dir_up), 32'h1);
    step(1);
    chk("a_after_hs", 32'({req_valid, req_floor}), 32'h00);
    call_btn[5]   = 1'b0;
    current_floor = 4'd5;
    arrived       = 1'b1;
    step(1);
    arrived = 1'b0;
    chk("a_arrive_clr", 32'(pending), 32'h0);
    step(8);
    chk("a_idle_valid", 32'(req_valid), 32'h0);

    // Bounce: 2-cycle pulses never satisfy a 4-sample debounce.
    for (int i = 0; i < 4; i++) begin
      call_btn[3] = 1'b1;
      step(2);
      call_btn[3] = 1'b0;
      step(2);
    end
    step(10);
    chk("b_bounce_pend", 32'(pending), 32'h0);
    chk("b_bounce_valid", 32'(req_valid), 32'h0);

    // Sweep: from floor 6 going up with {3,9} pending.
    current_floor = 4'd6;
    call_btn[3]   = 1'b1;
    call_btn[9]   = 1'b1;
    step(7);
    chk("c_pend", 32'(pending), 32'h0208);
    step(2);
    chk("c_offer9", 32'({req_valid, req_floor}), 32'h19);
    chk("c_dir_up", 32'(dir_up), 32'h1);
    call_btn[3] = 1'b0;
    call_btn[9] = 1'b0;
    step(1);
    chk("c_hs9", 32'(req_valid), 32'h0);
    current_floor = 4'd9;
    arrived       = 1'b1;
    step(1);
    arrived = 1'b0;
    chk("c_clr9", 32'(pending), 32'h0008);
    step(2);
    chk("c_offer3", 32'({req_valid, req_floor}), 32'h13);
    chk("c_dir_down", 32'(dir_up), 32'h0);
    step(1);
    current_floor = 4'd3;
    arrived       = 1'b1;
    step(1);
    arrived = 1'b0;
    chk("c_clr3", 32'(pending), 32'h0);

    // Held offer: floor 4 with req_ready low for 7 cycles, handshake on the 8th.
    req_ready   = 1'b0;
    call_btn[4] = 1'b1;
    step(9);
    chk("d_dir_turn", 32'(dir_up), 32'h1);
    for (int i = 1; i <= 7; i++) begin
      chk($sformatf("d_hold%0d", i), 32'({req_valid, req_floor}), 32'h14);
      step(1);
    end
    call_btn[4] = 1'b0;
    chk("d_hold8", 32'({req_valid, req_floor}), 32'h14);
    req_ready = 1'b1;
    step(1);
    chk("d_hs", 32'({req_valid, req_floor}), 32'h00);

    // Arrival at a non-target floor clears only that floor and keeps waiting.
    call_btn[10] = 1'b1;
    step(7);
    chk("d_pend2", 32'(pending), 32'h0410);
    call_btn[10]  = 1'b0;
    current_floor = 4'd10;
    arrived       = 1'b1;
    step(1);
    arrived = 1'b0;
    chk("d_clr10", 32'(pending), 32'h0010);
    step(3);
    chk("d_still_wait", 32'(req_valid), 32'h0);
    current_floor = 4'd4;
    arrived       = 1'b1;
    step(1);
    arrived = 1'b0;
    chk("d_clr4", 32'(pending), 32'h0);

    // Clear beats set: floor 7 latches on the same edge it is arrived at.
    call_btn[12] = 1'b1;
    step(9);
    chk("e_offer12", 32'({req_valid, req_floor}), 32'h1C);
    call_btn[12] = 1'b0;
    step(1);
    call_btn[7] = 1'b1;
    step(6);
    current_floor = 4'd7;
    arrived       = 1'b1;
    step(1);
    arrived = 1'b0;
    chk("e_clear_wins", 32'(pending), 32'h1000);
    chk("e_wait_valid", 32'(req_valid), 32'h0);
    call_btn[7]   = 1'b0;
    current_floor = 4'd12;
    arrived       = 1'b1;
    step(1);
    arrived = 1'b0;
    chk("e_clr12", 32'(pending), 32'h0);

    // Floor 0 is never latched and never offered.
    saw_valid   = 1'b0;
    call_btn[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (i == 10) call_btn[0] = 1'b0;
      saw_valid = saw_valid | req_valid;
    end
    chk("e_floor0_pend", 32'(pending), 32'h0);
    chk("e_floor0_offer", 32'(saw_valid), 32'h0);

    // Reset in WAIT_ARRIVE with {2,8} pending; held buttons re-register afterwards.
    call_btn[2] = 1'b1;
    call_btn[8] = 1'b1;
    step(9);
    chk("f_offer8", 32'({req_valid, req_floor}), 32'h18);
    step(1);
    chk("f_pend", 32'(pending), 32'h0104);
    chk("f_dir", 32'(dir_up), 32'h0);
    reset = 1'b1;
    #1;
    chk("f_rst_pend", 32'(pending), 32'h0);
    chk("f_rst_valid", 32'({req_valid, req_floor}), 32'h00);
    chk("f_rst_dir", 32'(dir_up), 32'h1);
    step(3);
    reset = 1'b0;
    step(6);
    chk("f_held_early", 32'(pending), 32'h0);
    step(1);
    chk("f_held_edge", 32'(pending), 32'h0104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
